// File: rtl/rx_core_param.sv
// Parametrised UART receiver: oversampled, majority-voted deframer feeding a
// first-word-fall-through FIFO that stores {frame error, parity error, data}.
module rx_core_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            AcqSig_i,
  input  logic                            Rx_i,
  input  logic                            p_ParityEnable_i,
  input  logic                            ParityMethod_i,
  input  logic                            p_BigEnd_i,
  input  logic                            p_TwoStop_i,
  input  logic                            n_rd_i,
  input  logic                            p_ErrClear_i,
  output logic [DATA_W-1:0]               data_o,
  output logic                            p_ParityError_o,
  output logic                            p_FrameError_o,
  output logic                            p_empty_o,
  output logic                            p_full_o,
  output logic [$clog2(FIFO_DEPTH):0]     Count_o,
  output logic                            p_Overrun_o,
  output logic                            p_Break_o,
  output logic [2:0]                      State_o
);

  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_W);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 2;
  localparam int H       = OVERSAMPLE / 2;

  localparam logic [SC_W-1:0] SC_SMP_A = SC_W'(H - 1);
  localparam logic [SC_W-1:0] SC_SMP_B = SC_W'(H);
  localparam logic [SC_W-1:0] SC_DECIDE = SC_W'(H + 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_rx_meta, r_rx_s, r_rx_last;
  logic [SC_W-1:0]     r_sc;
  logic [BC_W-1:0]     r_bit_cnt;
  logic                r_stop_cnt;
  logic                r_smp_a, r_smp_b;
  logic [DATA_W-1:0]   r_data;
  logic                r_fe, r_pe;
  logic                r_par_en, r_par_odd, r_big, r_two;

  logic                w_start_edge, w_sc_wrap, w_decide, w_vote;
  logic                w_final_stop, w_fe_final, w_push_req;

  // Synchroniser; r_rx_last holds Rx_s as seen on the previous strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_last <= 1'b1;
    end else begin
      r_rx_meta <= Rx_i;
      r_rx_s    <= r_rx_meta;
      if (AcqSig_i) r_rx_last <= r_rx_s;
    end
  end

  assign w_start_edge = AcqSig_i && r_rx_last && !r_rx_s;
  assign w_sc_wrap    = (r_sc == SC_LAST);
  assign w_decide     = AcqSig_i && (r_sc == SC_DECIDE);
  assign w_vote       = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);
  assign w_final_stop = !r_two || r_stop_cnt;
  assign w_fe_final   = r_fe | ~w_vote;
  assign w_push_req   = (r_state == S_STOP) && w_decide && w_final_stop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_edge) w_state_next = S_START;
      S_START: begin
        if (w_decide && w_vote)            w_state_next = S_IDLE;
        else if (AcqSig_i && w_sc_wrap)    w_state_next = S_DATA;
      end
      S_DATA:
        if (AcqSig_i && w_sc_wrap && (r_bit_cnt == BC_LAST))
          w_state_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (AcqSig_i && w_sc_wrap) w_state_next = S_STOP;
      S_STOP:   if (w_push_req) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    State_o   = r_state;
    p_Break_o = w_push_req && w_fe_final && (r_data == '0);
  end

  // Bit timing and deframing datapath; everything advances on the strobe only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc       <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_smp_a    <= 1'b1;
      r_smp_b    <= 1'b1;
      r_data     <= '0;
      r_fe       <= 1'b0;
      r_pe       <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_big      <= 1'b0;
      r_two      <= 1'b0;
    end else if (AcqSig_i) begin
      if (r_state == S_IDLE) begin
        if (w_start_edge) begin
          r_par_en   <= p_ParityEnable_i;
          r_par_odd  <= ParityMethod_i;
          r_big      <= p_BigEnd_i;
          r_two      <= p_TwoStop_i;
          r_sc       <= '0;
          r_bit_cnt  <= '0;
          r_stop_cnt <= 1'b0;
          r_data     <= '0;
          r_fe       <= 1'b0;
          r_pe       <= 1'b0;
        end
      end else begin
        r_sc <= w_sc_wrap ? '0 : r_sc + SC_W'(1);
        if (r_sc == SC_SMP_A) r_smp_a <= r_rx_s;
        if (r_sc == SC_SMP_B) r_smp_b <= r_rx_s;
        if (w_decide) begin
          case (r_state)
            S_DATA: begin
              if (r_big) r_data <= {r_data[DATA_W-2:0], w_vote};
              else       r_data <= {w_vote, r_data[DATA_W-1:1]};
            end
            S_PARITY: r_pe <= w_vote ^ (^r_data) ^ r_par_odd;
            S_STOP:   if (!w_vote) r_fe <= 1'b1;
            default:  ;
          endcase
        end
        if (w_sc_wrap) begin
          if (r_state == S_DATA) r_bit_cnt  <= r_bit_cnt + BC_W'(1);
          if (r_state == S_STOP) r_stop_cnt <= 1'b1;
        end
      end
    end
  end

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_last_pop;
  logic               r_overrun;
  logic               w_full, w_empty, w_do_pop, w_do_push, w_overrun_set;
  logic [ENTRY_W-1:0] w_head, w_entry;

  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_do_pop      = !n_rd_i && !w_empty;
  assign w_do_push     = w_push_req && (!w_full || w_do_pop);
  assign w_overrun_set = w_push_req && w_full && !w_do_pop;
  assign w_entry       = {w_fe_final, r_pe, r_data};

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_pop <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_last_pop <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      if (w_overrun_set)     r_overrun <= 1'b1;
      else if (p_ErrClear_i) r_overrun <= 1'b0;
    end
  end

  // An empty FIFO keeps presenting the most recently popped word.
  assign w_head          = w_empty ? r_last_pop : r_mem[r_rd_ptr];
  assign data_o          = w_head[DATA_W-1:0];
  assign p_ParityError_o = w_head[DATA_W];
  assign p_FrameError_o  = w_head[DATA_W+1];
  assign p_empty_o       = w_empty;
  assign p_full_o        = w_full;
  assign Count_o         = r_count;
  assign p_Overrun_o     = r_overrun;

endmodule

// File: tb/tb_rx_core_param.sv
// Scoreboard bench for rx_core_param: frames are built from random words and
// modes, the expected FIFO entry is queued at issue and checked on each pop.
`timescale 1ns/1ps
module tb_rx_core_param;

  localparam int DATA_W  = 8;
  localparam int OS      = 16;
  localparam int DEPTH   = 16;
  localparam int ACQ_DIV = 4;
  localparam int BIT_CLK = OS * ACQ_DIV;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic clk, rst, AcqSig_i, Rx_i;
  logic p_ParityEnable_i, ParityMethod_i, p_BigEnd_i, p_TwoStop_i;
  logic n_rd_i, p_ErrClear_i;
  logic [DATA_W-1:0] data_o;
  logic p_ParityError_o, p_FrameError_o, p_empty_o, p_full_o;
  logic [CNT_W-1:0] Count_o;
  logic p_Overrun_o, p_Break_o;
  logic [2:0] State_o;

  rx_core_param #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .AcqSig_i(AcqSig_i), .Rx_i(Rx_i),
    .p_ParityEnable_i(p_ParityEnable_i), .ParityMethod_i(ParityMethod_i),
    .p_BigEnd_i(p_BigEnd_i), .p_TwoStop_i(p_TwoStop_i),
    .n_rd_i(n_rd_i), .p_ErrClear_i(p_ErrClear_i),
    .data_o(data_o), .p_ParityError_o(p_ParityError_o),
    .p_FrameError_o(p_FrameError_o), .p_empty_o(p_empty_o),
    .p_full_o(p_full_o), .Count_o(Count_o), .p_Overrun_o(p_Overrun_o),
    .p_Break_o(p_Break_o), .State_o(State_o)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              pe;
    logic              fe;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    read_en = 1'b0;
  bit    exp_overrun = 1'b0;
  int    break_cnt = 0;
  int    exp_break = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int acq_cnt;
    acq_cnt  = 0;
    AcqSig_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      acq_cnt  = (acq_cnt + 1) % ACQ_DIV;
      AcqSig_i = (acq_cnt == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever reading is enabled and a word is presented.
  initial begin
    word_t e;
    n_rd_i = 1'b1;
    forever begin
      @(negedge clk);
      if (read_en && !rst && !p_empty_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got data %02h, required no word", data_o);
        end else begin
          e = exp_q.pop_front();
          $display("POP data=%02h pe=%0b fe=%0b", data_o, p_ParityError_o, p_FrameError_o);
          chk("pop_data", 32'(data_o), 32'(e.data));
          chk("pop_pe", 32'(p_ParityError_o), 32'(e.pe));
          chk("pop_fe", 32'(p_FrameError_o), 32'(e.fe));
        end
        n_rd_i = 1'b0;
        @(posedge clk);
        #1;
        n_rd_i = 1'b1;
      end
    end
  end

  always @(negedge clk) if (p_Break_o) break_cnt++;

  task automatic line(input logic v, input int nbits);
    Rx_i = v;
    repeat (nbits * BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic sync_in();
    @(posedge clk);
    #1;
  endtask

  // Builds and transmits one frame; the expected entry comes from the frame's
  // contents: the correct parity bit makes data+parity even (or odd), and any
  // low stop bit is a framing error.
  task automatic send_frame(input logic [DATA_W-1:0] d, input bit par_en, input bit odd,
                            input bit big, input bit two, input bit par_ok,
                            input bit stop0, input bit stop1, input bit scramble);
    word_t w;
    int    ones;
    bit    good_par;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    good_par = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    w.data = d;
    w.pe   = par_en && !par_ok;
    w.fe   = !stop0 || (two && !stop1);
    if (!read_en && exp_q.size() >= DEPTH) exp_overrun = 1'b1;
    else exp_q.push_back(w);
    if (d == 0 && w.fe) exp_break++;
    p_ParityEnable_i = par_en;
    ParityMethod_i   = odd;
    p_BigEnd_i       = big;
    p_TwoStop_i      = two;
    line(1'b0, 1);
    if (scramble) begin
      p_ParityEnable_i = 1'($urandom);
      ParityMethod_i   = 1'($urandom);
      p_BigEnd_i       = 1'($urandom);
      p_TwoStop_i      = 1'($urandom);
    end
    for (int i = 0; i < DATA_W; i++) line(big ? d[DATA_W-1-i] : d[i], 1);
    if (par_en) line(par_ok ? good_par : !good_par, 1);
    line(stop0, 1);
    if (two) line(stop1, 1);
    line(1'b1, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !p_empty_o) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 20000), 32'd1);
    if (n >= 20000) exp_q.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int bk;
    rst = 1'b1;
    Rx_i = 1'b1;
    p_ParityEnable_i = 1'b0;
    ParityMethod_i = 1'b0;
    p_BigEnd_i = 1'b0;
    p_TwoStop_i = 1'b0;
    p_ErrClear_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_state", 32'(State_o), 32'd0);
    chk("rst_count", 32'(Count_o), 32'd0);
    chk("rst_empty", 32'(p_empty_o), 32'd1);
    chk("rst_full", 32'(p_full_o), 32'd0);
    chk("rst_overrun", 32'(p_Overrun_o), 32'd0);
    chk("rst_break", 32'(p_Break_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_flags", 32'({p_ParityError_o, p_FrameError_o}), 32'd0);

    // 8N1 0xA5 held in the FIFO, then popped
    sync_in();
    send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    chk("a5_count", 32'(Count_o), 32'd1);
    chk("a5_empty", 32'(p_empty_o), 32'd0);
    chk("a5_data", 32'(data_o), 32'hA5);
    chk("a5_flags", 32'({p_ParityError_o, p_FrameError_o}), 32'd0);
    read_en = 1'b1;
    wait_drain();
    chk("a5_empty_after_pop", 32'(p_empty_o), 32'd1);
    chk("a5_hold_last", 32'(data_o), 32'hA5);

    // 8E1 wrong then right parity
    sync_in();
    send_frame(8'h3C, 1, 0, 0, 0, 0, 1, 1, 0);
    send_frame(8'h3C, 1, 0, 0, 0, 1, 1, 1, 0);
    wait_drain();

    // short low glitch is a false start
    sync_in();
    Rx_i = 1'b0;
    repeat (4 * ACQ_DIV) @(posedge clk);
    #1 Rx_i = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    @(negedge clk);
    chk("glitch_state", 32'(State_o), 32'd0);
    chk("glitch_count", 32'(Count_o), 32'd0);

    // fill to full, then one overrun
    read_en = 1'b0;
    sync_in();
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(DATA_W'(i), 0, 0, 0, 0, 1, 1, 1, 0);
      if (i == DEPTH - 1) begin
        @(negedge clk);
        chk("fill_full", 32'(p_full_o), 32'd1);
        chk("fill_no_overrun", 32'(p_Overrun_o), 32'd0);
        sync_in();
      end
    end
    @(negedge clk);
    chk("ovr_count", 32'(Count_o), 32'(exp_q.size()));
    chk("ovr_full", 32'(p_full_o), 32'd1);
    chk("ovr_flag", 32'(p_Overrun_o), 32'(exp_overrun));
    chk("ovr_head", 32'(data_o), 32'(exp_q[0].data));
    sync_in();
    p_ErrClear_i = 1'b1;
    sync_in();
    p_ErrClear_i = 1'b0;
    exp_overrun = 1'b0;
    @(negedge clk);
    chk("errclear", 32'(p_Overrun_o), 32'(exp_overrun));
    read_en = 1'b1;
    wait_drain();
    chk("drained_full", 32'(p_full_o), 32'd0);

    // break: line low for 12 bit times, then a normal frame
    bk = break_cnt;
    sync_in();
    p_ParityEnable_i = 1'b0;
    p_BigEnd_i = 1'b0;
    p_TwoStop_i = 1'b0;
    exp_q.push_back('{data: '0, pe: 1'b0, fe: 1'b1});
    exp_break++;
    line(1'b0, 12);
    line(1'b1, 2);
    chk("break_pulses", 32'(break_cnt - bk), 32'd1);
    send_frame(8'h55, 0, 0, 0, 0, 1, 1, 1, 0);
    wait_drain();

    // big-end, two stop bits: second stop low, then both high
    sync_in();
    send_frame(8'h80, 0, 0, 1, 1, 1, 1, 0, 0);
    send_frame(8'h80, 0, 0, 1, 1, 1, 1, 1, 0);
    wait_drain();

    // random frames with mode inputs disturbed mid-frame
    sync_in();
    for (int n = 0; n < 24; n++) begin
      d = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
      send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 5) != 0), 1);
    end
    wait_drain();
    chk("final_breaks", 32'(break_cnt), 32'(exp_break));
    chk("final_overrun", 32'(p_Overrun_o), 32'(exp_overrun));
    chk("final_state", 32'(State_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
